// File: rtl/clb_pkg.sv
// Shared types and LUT-slice layout helpers for the configurable logic tile.
package clb_pkg;

    typedef enum logic [1:0] {
        StUncfg  = 2'd0,
        StLoad   = 2'd1,
        StActive = 2'd2
    } clb_state_e;

    // Configuration bits per LUT: K selects, 2**K truth bits, one reg_en bit.
    function automatic int unsigned lut_bits(input int unsigned k, input int unsigned sel_w);
        return k * sel_w + (32'd1 << k) + 32'd1;
    endfunction

    function automatic int unsigned sel_off(input int unsigned j, input int unsigned sel_w);
        return j * sel_w;
    endfunction

    function automatic int unsigned truth_off(input int unsigned k, input int unsigned sel_w);
        return k * sel_w;
    endfunction

    function automatic int unsigned reg_en_off(input int unsigned k, input int unsigned sel_w);
        return k * sel_w + (32'd1 << k);
    endfunction

endpackage

// File: rtl/clb_lut.sv
// One K-input LUT: source crossbar, truth-table lookup, optional output register.
module clb_lut
    import clb_pkg::*;
#(
    parameter int unsigned LUT_K    = 4,
    parameter int unsigned SRC_N    = 16,
    parameter int unsigned SEL_W    = 4,
    parameter int unsigned LUT_BITS = lut_bits(LUT_K, SEL_W)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                active,
    input  logic                run,
    input  logic [LUT_BITS-1:0] cfg,
    input  logic [SRC_N-1:0]    src,
    output logic                q,
    output logic                lut_out
);

    localparam int unsigned TT_N       = 2 ** LUT_K;
    localparam int unsigned TRUTH_LO   = truth_off(LUT_K, SEL_W);
    localparam int unsigned REG_EN_POS = reg_en_off(LUT_K, SEL_W);

    logic [LUT_K-1:0] lut_in;
    logic [TT_N-1:0]  truth;
    logic             reg_en;
    logic             comb_val;
    logic             q_q;

    assign truth  = cfg[TRUTH_LO +: TT_N];
    assign reg_en = cfg[REG_EN_POS];

    // Select indices beyond the source bus read as constant 0.
    always_comb begin
        lut_in = '0;
        for (int unsigned j = 0; j < LUT_K; j++) begin
            if (32'(cfg[sel_off(j, SEL_W) +: SEL_W]) < SRC_N) begin
                lut_in[j] = src[cfg[sel_off(j, SEL_W) +: SEL_W]];
            end
        end
    end

    assign comb_val = truth[lut_in];

    always_ff @(posedge clk) begin
        if (rst || !run) begin
            q_q <= 1'b0;
        end else begin
            q_q <= comb_val;
        end
    end

    assign q       = q_q;
    assign lut_out = active ? (reg_en ? q_q : comb_val) : 1'b0;

endmodule

// File: rtl/clb_tile.sv
// Configurable logic tile: serial config chain, load FSM and NUM_LUTS LUTs with feedback.
// Optional CLB_READBACK_EN streams the displaced configuration out on cfg_dout.
module clb_tile
    import clb_pkg::*;
#(
    parameter int unsigned LUT_K    = 4,
    parameter int unsigned NUM_LUTS = 8,
    parameter int unsigned NUM_IN   = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_IN-1:0]   in_i,
    output logic [NUM_LUTS-1:0] out_o,
    input  logic                cfg_start,
    input  logic                cfg_valid,
    input  logic                cfg_bit,
    output logic                cfg_ready,
    output logic                cfg_done,
    output logic                cfg_dout
);

    localparam int unsigned SRC_N    = NUM_IN + NUM_LUTS;
    localparam int unsigned SEL_W    = $clog2(SRC_N);
    localparam int unsigned LUT_BITS = lut_bits(LUT_K, SEL_W);
    localparam int unsigned CFG_BITS = NUM_LUTS * LUT_BITS;
    localparam int unsigned CNT_W    = $clog2(CFG_BITS + 1);
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(CFG_BITS - 1);

    clb_state_e          state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [CFG_BITS-1:0] chain_q, chain_d;
    logic                beat;
    logic                active;
    logic                run;
    logic [NUM_LUTS-1:0] lut_q;
    logic [SRC_N-1:0]    src;

    assign cfg_ready = (state_q == StLoad) && !cfg_start;
    assign beat      = cfg_valid && cfg_ready;
    assign active    = (state_q == StActive);
    // A restart in ACTIVE clears the LUT registers on the same edge.
    assign run       = active && !cfg_start;
    assign cfg_done  = active;
    assign src       = {lut_q, in_i};

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        chain_d = chain_q;
        if (cfg_start) begin
            state_d = StLoad;
            cnt_d   = '0;
        end else begin
            case (state_q)
                StLoad: begin
                    if (beat) begin
                        chain_d = {cfg_bit, chain_q[CFG_BITS-1:1]};
                        cnt_d   = cnt_q + 1'b1;
                        if (cnt_q == LAST_BEAT) begin
                            state_d = StActive;
                        end
                    end
                end
                StUncfg, StActive: begin
                    state_d = state_q;
                end
                default: begin
                    state_d = StUncfg;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StUncfg;
            cnt_q   <= '0;
            chain_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            chain_q <= chain_d;
        end
    end

`ifdef CLB_READBACK_EN
    logic dout_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            dout_q <= 1'b0;
        end else if (beat) begin
            dout_q <= chain_q[0];
        end
    end

    assign cfg_dout = dout_q;
`else
    assign cfg_dout = 1'b0;
`endif

    for (genvar i = 0; i < NUM_LUTS; i++) begin : g_lut
        clb_lut #(
            .LUT_K   (LUT_K),
            .SRC_N   (SRC_N),
            .SEL_W   (SEL_W),
            .LUT_BITS(LUT_BITS)
        ) u_lut (
            .clk    (clk),
            .rst    (rst),
            .active (active),
            .run    (run),
            .cfg    (chain_q[i*LUT_BITS +: LUT_BITS]),
            .src    (src),
            .q      (lut_q[i]),
            .lut_out(out_o[i])
        );
    end

endmodule

// File: tb/tb_clb_tile.sv
// Self-checking bench for clb_tile: directed scenarios plus random configs, checked
// every cycle against a history-queue behavioural model of the tile.
module tb_clb_tile;

    localparam int K  = 4;
    localparam int NL = 8;
    localparam int NI = 8;
    localparam int SW = 4;
    localparam int LB = K * SW + 16 + 1;
    localparam int CB = NL * LB;
`ifdef CLB_READBACK_EN
    localparam bit RB = 1'b1;
`else
    localparam bit RB = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NI-1:0] in_i = '0;
    logic [NL-1:0] out_o;
    logic          cfg_start = 1'b0;
    logic          cfg_valid = 1'b0;
    logic          cfg_bit = 1'b0;
    logic          cfg_ready, cfg_done, cfg_dout;

    always #5 clk = ~clk;

    clb_tile dut (
        .clk      (clk),
        .rst      (rst),
        .in_i     (in_i),
        .out_o    (out_o),
        .cfg_start(cfg_start),
        .cfg_valid(cfg_valid),
        .cfg_bit  (cfg_bit),
        .cfg_ready(cfg_ready),
        .cfg_done (cfg_done),
        .cfg_dout (cfg_dout)
    );

    int n_chk = 0;
    int n_pass = 0;

    // Model: every accepted bit since reset, preceded by CB zeros; chain bit j = hist[total+j].
    bit hist[$];
    int total;
    int m_st;   // 0 unconfigured, 1 loading, 2 active
    int m_cnt;
    bit m_q[NL];
    bit m_dout;

    // Configuration being sent.
    int        c_sel[NL][K];
    bit [15:0] c_truth[NL];
    bit        c_reg[NL];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic reset_model();
        hist.delete();
        for (int i = 0; i < CB; i++) hist.push_back(1'b0);
        total = 0;
        m_st = 0;
        m_cnt = 0;
        m_dout = 1'b0;
        for (int i = 0; i < NL; i++) m_q[i] = 1'b0;
    endtask

    function automatic bit chain_bit(input int j);
        return hist[total + j];
    endfunction

    function automatic int field(input int lo, input int w);
        int v = 0;
        for (int b = 0; b < w; b++) v |= int'(chain_bit(lo + b)) << b;
        return v;
    endfunction

    function automatic bit src_val(input int s);
        if (s < NI) return in_i[s];
        if (s < NI + NL) return m_q[s - NI];
        return 1'b0;
    endfunction

    function automatic bit lut_comb(input int i);
        int idx = 0;
        for (int j = 0; j < K; j++) idx |= int'(src_val(field(i * LB + j * SW, SW))) << j;
        return chain_bit(i * LB + K * SW + idx);
    endfunction

    function automatic logic [NL-1:0] m_out();
        logic [NL-1:0] o = '0;
        if (m_st == 2) begin
            for (int i = 0; i < NL; i++)
                o[i] = chain_bit(i * LB + LB - 1) ? m_q[i] : lut_comb(i);
        end
        return o;
    endfunction

    function automatic bit cfg_bit_of(input int b);
        int l = b / LB;
        int off = b % LB;
        if (off < K * SW) return c_sel[l][off / SW][off % SW];
        if (off < K * SW + 16) return c_truth[l][off - K * SW];
        return c_reg[l];
    endfunction

    task automatic clear_cfg();
        for (int i = 0; i < NL; i++) begin
            for (int j = 0; j < K; j++) c_sel[i][j] = 0;
            c_truth[i] = '0;
            c_reg[i] = 1'b0;
        end
    endtask

    // One clock cycle: drive, check against model, advance model across the edge.
    task automatic cyc(input bit r, input bit st, input bit v, input bit b,
                       input logic [NI-1:0] in);
        bit nq[NL];
        bit beat;
        rst = r;
        cfg_start = st;
        cfg_valid = v;
        cfg_bit = b;
        in_i = in;
        #2;
        if (!r) begin
            chk("out_o", 32'(out_o), 32'(m_out()));
            chk("cfg_ready", 32'(cfg_ready), 32'(m_st == 1 && !st));
            chk("cfg_done", 32'(cfg_done), 32'(m_st == 2));
            chk("cfg_dout", 32'(cfg_dout), 32'(m_dout));
        end
        if (r) begin
            reset_model();
        end else begin
            beat = v && (m_st == 1) && !st;
            for (int i = 0; i < NL; i++) nq[i] = (m_st == 2 && !st) ? lut_comb(i) : 1'b0;
            if (beat && RB) m_dout = hist[total];
            if (beat) begin
                hist.push_back(b);
                total++;
            end
            m_q = nq;
            if (st) begin
                m_st = 1;
                m_cnt = 0;
            end else if (beat) begin
                m_cnt++;
                if (m_cnt == CB) m_st = 2;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic load_bits(input int from, input int to, input bit gaps);
        int b = from;
        bit v;
        while (b < to) begin
            v = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            cyc(1'b0, 1'b0, v, cfg_bit_of(b), 8'($urandom));
            if (v) b++;
        end
    endtask

    task automatic restart_and_load(input bit gaps);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'($urandom));
        load_bits(0, CB, gaps);
    endtask

    task automatic set_and4(input bit reg_en);
        clear_cfg();
        for (int j = 0; j < K; j++) c_sel[0][j] = j;
        c_truth[0] = 16'h8000;
        c_reg[0] = reg_en;
    endtask

    initial begin
        reset_model();
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'hFF);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1, 8'hFF);
        chk("idle_ready", 32'(cfg_ready), 32'd0);
        chk("idle_out", 32'(out_o), 32'd0);

        // AND4, combinational output
        set_and4(1'b0);
        restart_and_load(1'b0);
        chk("and4_done", 32'(cfg_done), 32'd1);
        in_i = 8'h0F;
        #1;
        chk("and4_hi", 32'(out_o[0]), 32'd1);
        in_i = 8'h0E;
        #1;
        chk("and4_lo", 32'(out_o[0]), 32'd0);
        for (int i = 0; i < 16; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom) | 8'(i % 2 * 15));

        // AND4, registered output
        set_and4(1'b1);
        restart_and_load(1'b0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        in_i = 8'h0F;
        #1;
        chk("reg_same_cycle", 32'(out_o[0]), 32'd0);
        cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h0F);
        chk("reg_next_cycle", 32'(out_o[0]), 32'd1);
        for (int i = 0; i < 12; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));

        // Feedback toggler on LUT1
        clear_cfg();
        c_sel[1][0] = 9;
        c_truth[1] = 16'h5555;
        c_reg[1] = 1'b1;
        restart_and_load(1'b1);
        for (int k = 0; k < 8; k++) begin
            chk("toggle", 32'(out_o[1]), 32'(k % 2));
            cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));
        end

        // Restart after 100 beats, coincident with a valid bit
        set_and4(1'b0);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
        load_bits(0, 100, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b1, 8'h00);
        load_bits(0, CB - 1, 1'b0);
        chk("restart_not_done", 32'(cfg_done), 32'd0);
        load_bits(CB - 1, CB, 1'b0);
        chk("restart_done", 32'(cfg_done), 32'd1);
        for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));

        // Reset mid-load
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'hFF);
        load_bits(0, 50, 1'b0);
        cyc(1'b1, 1'b0, 1'b1, 1'b1, 8'hFF);
        chk("rst_ready", 32'(cfg_ready), 32'd0);
        chk("rst_out", 32'(out_o), 32'd0);
        chk("rst_done", 32'(cfg_done), 32'd0);
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);

        // Random configurations and inputs
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < NL; i++) begin
                for (int j = 0; j < K; j++) c_sel[i][j] = $urandom_range(0, 15);
                c_truth[i] = 16'($urandom);
                c_reg[i] = 1'($urandom);
            end
            restart_and_load(1'b1);
            for (int i = 0; i < 40; i++) cyc(1'b0, 1'b0, 1'($urandom), 1'b0, 8'($urandom));
        end

        // Readback: load A, then load B while A streams out on cfg_dout
        set_and4(1'b0);
        restart_and_load(1'b0);
        for (int i = 0; i < NL; i++) begin
            for (int j = 0; j < K; j++) c_sel[i][j] = $urandom_range(0, 15);
            c_truth[i] = 16'($urandom);
            c_reg[i] = 1'($urandom);
        end
        restart_and_load(1'b0);
        for (int i = 0; i < 4; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'($urandom));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
